// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one external signed Q5.11 multiplier among NUM_REQ requesters.
// Latency: accept at edge T, rsp_valid seen at edge T+2; backpressure holds RESP and deasserts every req_ready.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    output logic [15:0]             mul_in1,
    output logic [15:0]             mul_in2,
    input  logic [15:0]             mul_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [15:0]             rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [15:0]       mul_in1_q, mul_in1_d;
    logic [15:0]       mul_in2_q, mul_in2_d;
    logic [15:0]       rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

    logic              found_hi, found_lo;
    logic [ID_W-1:0]   grant_hi, grant_lo, grant;
    logic              any_vld;
    logic              accept;
    logic [15:0]       sel_a, sel_b;

    // Round robin: the first valid index above last_grant wins, else wrap to the lowest valid index.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        grant_hi = '0;
        grant_lo = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !found_lo) begin
                found_lo = 1'b1;
                grant_lo = ID_W'(i);
            end
            if (req_valid[i] && !found_hi && (ID_W'(i) > last_grant_q)) begin
                found_hi = 1'b1;
                grant_hi = ID_W'(i);
            end
        end
        grant   = found_hi ? grant_hi : grant_lo;
        any_vld = found_lo;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
            end
        end
    end

    assign accept = (state_q == IDLE) && any_vld;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_vld)   state_d = CALC;
            CALC:                   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = '0;
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
        if (accept) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (ID_W'(i) == grant);
            end
        end
    end

    // Operand registers keep their last values between transactions.
    always_comb begin
        mul_in1_d    = mul_in1_q;
        mul_in2_d    = mul_in2_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        if (accept) begin
            mul_in1_d    = sel_a;
            mul_in2_d    = sel_b;
            rsp_id_d     = grant;
            last_grant_d = grant;
        end
        if (state_q == CALC) begin
            rsp_data_d = mul_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_in1_q    <= '0;
            mul_in2_q    <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            mul_in1_q    <= mul_in1_d;
            mul_in2_q    <= mul_in2_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign mul_in1  = mul_in1_q;
    assign mul_in2  = mul_in2_q;
    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with an external Q5.11 multiplier model.
module tb_mult_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [15:0] mul_in1;
    logic [15:0] mul_in2;
    logic [15:0] mul_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mult_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_in1   (mul_in1),
        .mul_in2   (mul_in2),
        .mul_out   (mul_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // Shared multiplier: Q5.11 x Q5.11 -> Q10.22, truncated back to Q5.11.
    logic signed [31:0] prod;
    assign prod    = $signed(mul_in1) * $signed(mul_in2);
    assign mul_out = prod[26:11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, confirm it is granted combinationally, handshake, drop valid.
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input string tag);
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        req_valid[id]      = 1'b1;
        #1;
        check({tag, "_rdy"}, req_ready, 32'(4'b0001 << id));
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [1:0] id, input logic [15:0] d);
        int n;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_vld"}, rsp_valid, 1);
        check({tag, "_data"}, rsp_data, d);
        check({tag, "_id"}, rsp_id, id);
        tick();
        check({tag, "_drop"}, rsp_valid, 0);
    endtask

    function automatic int onehot_id(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    int gid [6];
    int gcyc[6];
    int ng;
    int n;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_mul_in1", mul_in1, 0);
        check("rst_rsp_id", rsp_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single request, exact latency: 1.0 * 2.0 = 2.0
        issue(0, 16'h0800, 16'h1000, "single");
        check("single_busy", busy, 1);
        check("single_calc_rdy", req_ready, 0);
        check("single_in1", mul_in1, 16'h0800);
        check("single_in2", mul_in2, 16'h1000);
        check("single_calc_vld", rsp_valid, 0);
        tick();
        check("single_t2_vld", rsp_valid, 1);
        expect_rsp("single", 2'd0, 16'h1000);
        check("single_idle", busy, 0);

        // Signed: -1.5 * 2.0 = -3.0
        issue(2, 16'hF400, 16'h1000, "signed");
        expect_rsp("signed", 2'd2, 16'hE800);

        // Leave last_grant at 3: 1.0 * 1.0
        issue(3, 16'h0800, 16'h0800, "r3");
        expect_rsp("r3", 2'd3, 16'h0800);

        // Pointer wrap: 1 and 3 pending with last_grant=3 -> 1 first, then 3
        req_a[16 +: 16] = 16'h0400; req_b[16 +: 16] = 16'h1000;
        req_a[48 +: 16] = 16'h1000; req_b[48 +: 16] = 16'h1000;
        req_valid = 4'b1010;
        #1;
        check("wrap_first", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        check("wrap_calc_rdy", req_ready, 0);
        expect_rsp("wrap1", 2'd1, 16'h0800);
        check("wrap_second", req_ready, 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        expect_rsp("wrap3", 2'd3, 16'h2000);

        // Backpressure: response from 0 stalled while 1 waits
        issue(0, 16'h0C00, 16'h1000, "bp0");
        rsp_ready = 1'b0;
        req_a[16 +: 16] = 16'hF800; req_b[16 +: 16] = 16'h0C00;
        req_valid[1] = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_vld", rsp_valid, 1);
            check("bp_data", rsp_data, 16'h1800);
            check("bp_id", rsp_id, 0);
            check("bp_rdy", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_rdy_last", req_ready, 0);
        tick();
        check("bp_vld_drop", rsp_valid, 0);
        check("bp_grant1", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        expect_rsp("bp_r1", 2'd1, 16'hF400);

        // Reset during CALC
        issue(2, 16'h0800, 16'h0800, "rstc");
        check("rstc_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rstc_busy0", busy, 0);
        check("rstc_in1", mul_in1, 0);
        check("rstc_in2", mul_in2, 0);
        check("rstc_data", rsp_data, 0);
        check("rstc_id", rsp_id, 0);
        check("rstc_vld", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rstc_no_rsp", rsp_valid, 0);
        end

        // Fairness from reset pointer: all requesters held valid
        for (int i = 0; i < 4; i++) begin
            req_a[16*i +: 16] = 16'h0800;
            req_b[16*i +: 16] = 16'h0800;
        end
        req_valid = 4'hF;
        ng = 0;
        for (int k = 0; k < 40 && ng < 6; k++) begin
            #1;
            if (req_ready != 0) begin
                gid[ng]  = onehot_id(req_ready);
                gcyc[ng] = k;
                ng++;
            end
            tick();
        end
        req_valid = '0;
        check("fair_count", ng, 6);
        for (int i = 0; i < 6; i++) begin
            check("fair_order", gid[i], i % 4);
            if (i > 0) check("fair_spacing", gcyc[i] - gcyc[i-1], 3);
        end
        n = 0;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        check("fair_drain", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one combinational signed Q5.11 multiplier (16x16 in, 16-bit out) among NUM_REQ requesters.
- Arbitration is round-robin.
- Each requester has a valid/ready request channel. All requesters share one response channel, tagged with the requester ID.
- Operands are registered before they drive the multiplier, and the result is registered after. This cuts the multiplier out of requester timing paths.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID. Must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  16*NUM_REQ  operand A, Q5.11 signed; requester i uses bits [16i+15:16i].
- req_b  in  16*NUM_REQ  operand B, Q5.11 signed; same packing as req_a.
- mul_in1  out  16  operand register A, drives the shared multiplier.
- mul_in2  out  16  operand register B, drives the shared multiplier.
- mul_out  in  16  shared multiplier result (Q5.11, truncated), combinational from mul_in1/mul_in2.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  16  registered product.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, immediate on rst_n low) forces:
  - state=IDLE; mul_in1=mul_in2=0; rsp_data=0; rsp_id=0.
  - rsp_valid=0; req_ready=0; busy=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority first.
- Reset asserted mid-operation aborts it. The in-flight result is discarded and no response is issued.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - req_ready[grant]=1 combinationally, only in IDLE and only if some req_valid is high.
  - On handshake: mul_in1<=req_a[grant], mul_in2<=req_b[grant], rsp_id<=grant, last_grant<=grant, go CALC.
  - No valid request: stay in IDLE; req_ready=0.
- CALC: exactly one cycle. rsp_data<=mul_out; go RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id held stable.
  - If rsp_ready=1 this cycle, go IDLE and drop rsp_valid next cycle.
  - Otherwise hold indefinitely; req_ready stays 0 (backpressure).
- Latency: request accepted at edge T → rsp_valid high at edge T+2. Minimum issue interval is 3 cycles with rsp_ready tied high.
- Arithmetic: the block never alters operands or result. mul_out is passed through bit-exact, with no saturation or rounding.
- Operand registers hold their last values between transactions. They are not cleared.
- Requester rules:
  - req_a/req_b must remain stable while req_valid is high and req_ready is low.
  - A requester may drop req_valid before being granted. It then simply loses arbitration.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester granted last has lowest priority on the next arbitration.
- Requesters with index >= NUM_REQ do not exist; rsp_id never exceeds NUM_REQ-1.

Test Plan:
- Single request: req_valid[0]=1, a=0x0800 (1.0), b=0x1000 (2.0), rsp_ready=1 → req_ready[0] at T; rsp_valid at T+2 with rsp_data=0x1000, rsp_id=0.
- Signed operands: req 2, a=0xF400 (-1.5), b=0x1000 (2.0) → rsp_data=0xE800 (-3.0), rsp_id=2.
- Fairness: all four req_valid held high continuously, rsp_ready=1 → grant order 0,1,2,3,0,1; each grant 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles during RESP, req_valid[1]=1 pending → rsp_valid/rsp_data/rsp_id stable and req_ready=0 throughout; req 1 granted the cycle after rsp_ready rises.
- Pointer wrap: last_grant=3, requests from 1 and 3 both pending → grant 1, then 3.
- Reset in CALC: rst_n low for 1 cycle mid-CALC → all outputs 0 immediately; no rsp_valid afterwards; next request from 0 is granted first.
